// File: rtl/voice_mix_source_if.sv
// ============================================================================
// Module      : voice_mix_source_if
// Description : Bus bundle between the voice mixer, the voice sample
//               providers, the gain register port and the I2S output core.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface voice_mix_source_if #(
   parameter int NV = 8,
   parameter int SW = 24,
   parameter int GW = 8,
   parameter int DW = 32
);
   localparam int c_SELW = $clog2(NV);

   logic                sampReq;
   logic [DW-1:0]       i2sDin;
   logic                outValid;
   logic                voiceReq;
   logic [c_SELW-1:0]   voiceSel;
   logic                voiceAck;
   logic [SW-1:0]       voiceSample;
   logic                gainWe;
   logic [c_SELW-1:0]   gainAddr;
   logic [GW-1:0]       gainData;
   logic                busy;
   logic [7:0]          underrunCnt;

   modport master (
      input  sampReq, voiceAck, voiceSample, gainWe, gainAddr, gainData,
      output i2sDin, outValid, voiceReq, voiceSel, busy, underrunCnt
   );

   modport slave (
      output sampReq, voiceAck, voiceSample, gainWe, gainAddr, gainData,
      input  i2sDin, outValid, voiceReq, voiceSel, busy, underrunCnt
   );
endinterface

`default_nettype wire

// File: rtl/voice_mix_source.sv
// ============================================================================
// Module      : voice_mix_source
// Description : Fetches, gain-scales and sums NV voice samples, then holds the
//               saturated mix as a left-justified word for the I2S core.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module voice_mix_source #(
   parameter int NV = 8,
   parameter int SW = 24,
   parameter int GW = 8,
   parameter int DW = 32
) (
   input  logic                 Clk,
   input  logic                 Reset,
   voice_mix_source_if.master   bus
);

   localparam int c_SELW = $clog2(NV);
   localparam int c_PW   = SW + GW + 1;
   localparam int c_AW   = SW + 1 + c_SELW;
   localparam logic [c_SELW-1:0]   c_LAST  = c_SELW'(NV - 1);
   localparam logic [GW-1:0]       c_UNITY = {1'b1, {(GW-1){1'b0}}};
   localparam logic signed [c_AW-1:0] c_MAX = {{(c_AW-SW+1){1'b0}}, {(SW-1){1'b1}}};
   localparam logic signed [c_AW-1:0] c_MIN = {{(c_AW-SW+1){1'b1}}, {(SW-1){1'b0}}};

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_REQ  = 3'd1,
      S_MUL  = 3'd2,
      S_ACC  = 3'd3,
      S_SAT  = 3'd4
   } state_t;

   state_t                  r_state, w_next;
   logic [GW-1:0]           r_gain [NV];
   logic signed [c_PW-1:0]  r_prod, r_shift;
   logic signed [c_AW-1:0]  r_acc;
   logic [c_SELW-1:0]       r_sel;
   logic [DW-1:0]           r_dout;
   logic                    r_valid;
   logic [7:0]              r_ur;

   logic signed [c_PW-1:0]  w_samp_x, w_gain_x, w_prod;
   logic signed [c_AW-1:0]  w_shift_x;
   logic [SW-1:0]           w_sat;
   logic [DW-1:0]           w_word;

   // Gain is zero-extended so the multiply treats it as unsigned.
   assign w_samp_x  = c_PW'($signed(bus.voiceSample));
   assign w_gain_x  = $signed(c_PW'(r_gain[r_sel]));
   assign w_prod    = w_samp_x * w_gain_x;
   assign w_shift_x = c_AW'(r_shift);
   assign w_sat     = (r_acc > c_MAX) ? SW'(c_MAX) :
                      (r_acc < c_MIN) ? SW'(c_MIN) : SW'(r_acc);
   assign w_word    = DW'(w_sat) << (DW - SW);

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE:  if (!r_valid || bus.sampReq) w_next = S_REQ;
         S_REQ:   if (bus.voiceAck) w_next = S_MUL;
         S_MUL:   w_next = S_ACC;
         S_ACC:   w_next = (r_sel == c_LAST) ? S_SAT : S_REQ;
         S_SAT:   w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         for (int i = 0; i < NV; i++) r_gain[i] <= c_UNITY;
      end else if (bus.gainWe) begin
         r_gain[bus.gainAddr] <= bus.gainData;
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_prod  <= '0;
         r_shift <= '0;
         r_acc   <= '0;
         r_sel   <= '0;
      end else begin
         case (r_state)
            S_IDLE: if (w_next == S_REQ) begin
               r_acc <= '0;
               r_sel <= '0;
            end
            S_REQ: if (bus.voiceAck) r_prod <= w_prod;
            S_MUL: r_shift <= r_prod >>> (GW - 1);
            S_ACC: begin
               r_acc <= r_acc + w_shift_x;
               if (r_sel != c_LAST) r_sel <= r_sel + 1'b1;
            end
            default: ;
         endcase
      end
   end

   // A consume strobe coinciding with SAT is absorbed by the new word.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_dout  <= '0;
         r_valid <= 1'b0;
         r_ur    <= '0;
      end else begin
         if (r_state == S_SAT) begin
            r_dout  <= w_word;
            r_valid <= 1'b1;
         end else if (bus.sampReq && r_valid) begin
            r_valid <= 1'b0;
         end
         if (bus.sampReq && !r_valid && (r_state != S_SAT) && (r_ur != 8'hFF))
            r_ur <= r_ur + 8'd1;
      end
   end

   assign bus.i2sDin      = r_dout;
   assign bus.outValid    = r_valid;
   assign bus.voiceReq    = (r_state == S_REQ);
   assign bus.voiceSel    = r_sel;
   assign bus.busy        = (r_state != S_IDLE);
   assign bus.underrunCnt = r_ur;

endmodule

`default_nettype wire

// File: tb/tb_voice_mix_source.sv
// ============================================================================
// Module      : tb_voice_mix_source
// Description : Directed scoreboard bench for voice_mix_source.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_voice_mix_source;
   localparam int NV = 8;
   localparam int SW = 24;
   localparam int GW = 8;
   localparam int DW = 32;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   voice_mix_source_if #(.NV(NV), .SW(SW), .GW(GW), .DW(DW)) vif ();

   voice_mix_source #(.NV(NV), .SW(SW), .GW(GW), .DW(DW)) dut (
      .Clk   (clk),
      .Reset (rst),
      .bus   (vif.master)
   );

   logic [SW-1:0] vs [NV];
   always_comb vif.voiceSample = vs[vif.voiceSel];

   int errors = 0;
   int checks = 0;
   logic [DW-1:0] expq [$];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Every fresh word (outValid rising) must match the oldest expectation.
   initial begin
      logic prev;
      prev = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev = 1'b0;
         end else begin
            if (vif.outValid && !prev) begin
               if (expq.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_word: got %0h expected none", vif.i2sDin);
               end else begin
                  chk("mix_word", vif.i2sDin, expq.pop_front());
               end
            end
            prev = vif.outValid;
         end
      end
   end

   task automatic write_gain(input int a, input int d);
      vif.gainWe   = 1'b1;
      vif.gainAddr = a[2:0];
      vif.gainData = d[7:0];
      @(negedge clk);
      vif.gainWe   = 1'b0;
   endtask

   task automatic clear_voices();
      for (int i = 0; i < NV; i++) vs[i] = '0;
   endtask

   task automatic run_frame(input bit delay, output int n, output int obs);
      int held;
      held = 0;
      obs  = 0;
      vif.sampReq = 1'b1;
      @(negedge clk);
      vif.sampReq = 1'b0;
      chk("consume_clears_valid", vif.outValid, 0);
      n = 1;
      while (!vif.outValid && n < 200) begin
         if (vif.voiceReq && vif.voiceSel == 2) begin
            obs++;
            if (delay) begin
               if (held < 5) begin
                  vif.voiceAck = 1'b0;
                  held++;
               end else begin
                  vif.voiceAck = 1'b1;
               end
            end
         end
         @(negedge clk);
         n++;
      end
      vif.voiceAck = 1'b1;
   endtask

   initial begin
      int n, obs, found;
      vif.sampReq  = 1'b0;
      vif.voiceAck = 1'b1;
      vif.gainWe   = 1'b0;
      vif.gainAddr = '0;
      vif.gainData = '0;
      clear_voices();
      vs[0] = 24'd1000;

      repeat (3) @(negedge clk);
      chk("rst_i2sDin", vif.i2sDin, 0);
      chk("rst_outValid", vif.outValid, 0);
      chk("rst_voiceReq", vif.voiceReq, 0);
      chk("rst_voiceSel", vif.voiceSel, 0);
      chk("rst_busy", vif.busy, 0);
      chk("rst_underrun", vif.underrunCnt, 0);

      // First frame: voice 0 = 1000 at unity; three underrun pulses meanwhile.
      expq.push_back(32'h0003E800);
      rst = 1'b0;
      n = 0;
      while (!vif.outValid && n < 200) begin
         vif.sampReq = (n == 3 || n == 5 || n == 7);
         @(negedge clk);
         n++;
      end
      vif.sampReq = 1'b0;
      chk("first_frame_cycles", n, 26);
      chk("underrun_3", vif.underrunCnt, 3);

      // Voice 3 = -4096 at half gain.
      clear_voices();
      vs[3] = 24'hFFF000;
      write_gain(3, 64);
      expq.push_back(32'hFFF80000);
      run_frame(1'b0, n, obs);
      chk("frame_len_min", n - 1, 25);
      chk("underrun_after_consume", vif.underrunCnt, 3);

      // Positive and negative saturation with max gain.
      for (int i = 0; i < NV; i++) write_gain(i, 255);
      for (int i = 0; i < NV; i++) vs[i] = 24'h7FFFFF;
      expq.push_back(32'h7FFFFF00);
      run_frame(1'b0, n, obs);
      for (int i = 0; i < NV; i++) vs[i] = 24'h800000;
      expq.push_back(32'h80000000);
      run_frame(1'b0, n, obs);

      // Voice 2 acknowledged 5 cycles late: 256*255>>7 = 510.
      clear_voices();
      vs[2] = 24'd256;
      expq.push_back(32'h0001FE00);
      run_frame(1'b1, n, obs);
      chk("frame_len_delayed", n - 1, 30);
      chk("req_held_voice2", obs, 6);

      // Consume strobe landing on the SAT edge: 128*255>>7 = 255.
      clear_voices();
      vs[1] = 24'd128;
      expq.push_back(32'h0000FF00);
      vif.sampReq = 1'b1;
      @(negedge clk);
      vif.sampReq = 1'b0;
      repeat (24) @(negedge clk);
      chk("pre_sat_valid", vif.outValid, 0);
      vif.sampReq = 1'b1;
      @(negedge clk);
      vif.sampReq = 1'b0;
      chk("sat_edge_valid", vif.outValid, 1);
      chk("sat_edge_underrun", vif.underrunCnt, 3);
      @(negedge clk);
      chk("sat_edge_valid_held", vif.outValid, 1);

      // Stall the frame and hammer sampReq: counter saturates.
      vif.voiceAck = 1'b0;
      vif.sampReq  = 1'b1;
      repeat (301) @(negedge clk);
      vif.sampReq  = 1'b0;
      chk("underrun_sat", vif.underrunCnt, 255);
      chk("stall_voiceReq", vif.voiceReq, 1);
      chk("stall_voiceSel", vif.voiceSel, 0);

      // Release the stall, abort with reset while in ACC of voice 4.
      vif.voiceAck = 1'b1;
      n = 0;
      found = 0;
      while (n < 100 && found == 0) begin
         if (vif.voiceReq && vif.voiceSel == 4) found = 1;
         else begin
            @(negedge clk);
            n++;
         end
      end
      chk("reach_voice4", found, 1);
      @(negedge clk);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("abort_i2sDin", vif.i2sDin, 0);
      chk("abort_outValid", vif.outValid, 0);
      chk("abort_voiceReq", vif.voiceReq, 0);
      chk("abort_voiceSel", vif.voiceSel, 0);
      chk("abort_busy", vif.busy, 0);
      chk("abort_underrun", vif.underrunCnt, 0);

      // After release, gains are unity again and the frame restarts at voice 0.
      clear_voices();
      vs[0] = 24'd1000;
      @(negedge clk);
      expq.push_back(32'h0003E800);
      rst = 1'b0;
      @(negedge clk);
      chk("restart_voiceReq", vif.voiceReq, 1);
      chk("restart_voiceSel", vif.voiceSel, 0);
      n = 1;
      while (!vif.outValid && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("restart_frame_cycles", n, 26);
      @(negedge clk);
      chk("queue_empty", expq.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/voice_mix_source.md
Name: voice_mix_source

Overview:
- Upstream feeder of the I2S output core, in the FCLK domain.
- Fetches one signed sample per synthesis voice over a req/ack handshake and scales each by a per-voice gain register.
- Sums the scaled samples, saturates the sum, and holds the result as a left-justified DW-bit word on i2sDin.
- A new mix frame starts whenever the held word is consumed by the core's sampReq write strobe.

Parameters:
- NV, 8, number of voices (power of 2, ≥2).
- SW, 24, voice sample and mixed sample width (signed).
- GW, 8, gain width (unsigned); unity gain = 2^(GW-1).
- DW, 32, output word width (DW ≥ SW).

Ports:
- Clk  in  1  system clock (FCLK).
- Reset  in  1  asynchronous, active-high reset.
- sampReq  in  1  consume strobe; the word on i2sDin is written downstream at this edge.
- i2sDin  out  DW  mixed sample, {sat[SW-1:0], (DW-SW) zeros}.
- outValid  out  1  i2sDin holds an unconsumed fresh sample.
- voiceReq  out  1  request sample from voice voiceSel.
- voiceSel  out  log2(NV)  voice index being requested.
- voiceAck  in  1  voiceSample valid; completes the handshake.
- voiceSample  in  SW  signed voice sample.
- gainWe  in  1  gain register write enable.
- gainAddr  in  log2(NV)  gain register index.
- gainData  in  GW  gain value.
- busy  out  1  mix frame in progress (state ≠ IDLE).
- underrunCnt  out  8  count of sampReq pulses seen while outValid=0; saturates at 255.

Behaviour:
- Interface: one clock, Clk; Reset is asynchronous and active-high.
- Reset values:
  - i2sDin=0, outValid=0, voiceReq=0, voiceSel=0, busy=0, underrunCnt=0.
  - Accumulator=0, state=IDLE.
  - All gain registers = 2^(GW-1).
- Reset asserted mid-frame aborts the frame immediately; no partial result reaches i2sDin.
- Gain writes:
  - Registered at posedge when gainWe=1; allowed in any state.
  - A write takes effect for any voice captured on a later edge.
  - A write on the same edge as that voice's capture does not apply; the old gain is used.
- FSM states: IDLE, REQ, MUL, ACC, SAT.
- IDLE:
  - Go to REQ when outValid=0, or when sampReq=1 at this edge.
  - On entry to REQ: accumulator cleared, voiceSel=0.
- REQ:
  - voiceReq=1 while in REQ; voiceSel stable.
  - Stay in REQ until voiceAck=1 at a posedge.
  - On that edge: product register = signed(voiceSample) × unsigned gain[voiceSel], width SW+GW+1. Go to MUL.
  - voiceAck outside REQ is ignored.
- MUL: product arithmetic-shifted right by GW-1 (truncate toward −∞). Go to ACC.
- ACC:
  - Accumulator += shifted product. Accumulator width SW+1+log2(NV) signed; it never wraps.
  - If voiceSel = NV-1, go to SAT; otherwise voiceSel+1 and go to REQ.
- SAT:
  - Clamp accumulator to [−2^(SW-1), 2^(SW-1)−1].
  - i2sDin ← {clamped, zeros}; outValid ← 1; go to IDLE.
- Minimum frame length = 3·NV+1 cycles from leaving IDLE (voiceAck tied high).
- Consume rules:
  - sampReq=1 with outValid=1: outValid ← 0 at that edge. i2sDin is unchanged until the next SAT, so downstream captures the old word.
  - sampReq=1 with outValid=0: underrunCnt +1 (holds at 255). i2sDin is unchanged and the stale word is written downstream.
  - sampReq=1 on the SAT edge: the SAT update wins, so outValid=1 with the new word. That pulse consumed the previous word and is not counted as an underrun.
- i2sDin only changes at a SAT edge or on reset. At most one word is outstanding, so an unconsumed word is never overwritten.

Test Plan:
- Single voice 0 = +1000, other voices = 0, all gains unity, voiceAck tied high:
  - After reset, first SAT at cycle 25 (NV=8).
  - i2sDin = 0x0003E800, outValid=1.
- Voice 3 = −4096 with gain[3] written to 64 (0.5×), others 0 → i2sDin = {24'hFFF800, 8'h00}.
- All 8 voices = 0x7FFFFF, gains 255 → clamp, i2sDin = 0x7FFFFF00.
- All 8 voices = 0x800000, gains 255 → clamp, i2sDin = 0x80000000.
- sampReq pulsed 3 times during the first frame (outValid=0) → underrunCnt=3.
- Hold underrun condition for 300 pulses → underrunCnt holds at 255.
- sampReq on the SAT edge → outValid stays 1, underrunCnt unchanged, new word present next cycle.
- voiceAck delayed 5 cycles for voice 2 → voiceReq and voiceSel=2 held for all 5 cycles; frame = 30 cycles.
- Reset asserted in ACC of voice 4 → all outputs at reset values immediately.
- After reset release, the next frame restarts from voiceSel=0 with unity gains.
